// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 memory responder.
package lc3_mem_pkg;

  localparam int LC3_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    PORT_INSTR,
    PORT_DATA
  } port_t;

endpackage

// File: rtl/lc3_mem_responder_if.sv
// Request/response bus between the LC3 fetch/memaccess stages, the
// memory responder and the single-port SRAM.
interface lc3_mem_responder_if;
  import lc3_mem_pkg::*;

  logic                  instr_req;
  logic [LC3_WORD_W-1:0] instr_addr;
  logic [LC3_WORD_W-1:0] instr_dout;
  logic                  complete_instr;

  logic                  data_req;
  logic                  data_we;
  logic [LC3_WORD_W-1:0] data_addr;
  logic [LC3_WORD_W-1:0] data_din;
  logic [LC3_WORD_W-1:0] data_dout;
  logic                  complete_data;

  logic [LC3_WORD_W-1:0] sram_addr;
  logic                  sram_we;
  logic [LC3_WORD_W-1:0] sram_wdata;
  logic [LC3_WORD_W-1:0] sram_rdata;

  logic                  busy;

  // Responder side.
  modport slave (
    input  instr_req, instr_addr, data_req, data_we, data_addr, data_din, sram_rdata,
    output instr_dout, complete_instr, data_dout, complete_data,
           sram_addr, sram_we, sram_wdata, busy
  );

  // Requester / SRAM side.
  modport master (
    output instr_req, instr_addr, data_req, data_we, data_addr, data_din, sram_rdata,
    input  instr_dout, complete_instr, data_dout, complete_data,
           sram_addr, sram_we, sram_wdata, busy
  );

endinterface

// File: rtl/lc3_mem_arbiter.sv
// Two-way round-robin arbiter: a lone requester wins; on a tie the port
// that was not granted last time wins.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
(
  input  logic  req_instr,
  input  logic  req_data,
  input  port_t last_grant,
  output port_t grant_id
);

  // Pick the winner among the current requesters.
  always_comb begin
    grant_id = PORT_INSTR;
    if (req_instr && req_data) begin
      grant_id = (last_grant == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
    end else if (req_data) begin
      grant_id = PORT_DATA;
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory responder: arbitrates the fetch and data ports onto one
// wait-stated single-port SRAM and produces the complete_* handshakes.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int CNT_W       = 4
) (
  input logic                clock,
  input logic                reset,
  lc3_mem_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               NO_WAIT  = (WAIT_STATES == 0);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  port_t                 last_grant;
  port_t                 grant_q;
  port_t                 grant_id;
  logic                  we_pending;
  logic                  done_instr;
  logic                  done_data;
  logic                  busy_q;
  logic [LC3_WORD_W-1:0] sram_addr_q;
  logic                  sram_we_q;
  logic [LC3_WORD_W-1:0] sram_wdata_q;
  logic [LC3_WORD_W-1:0] instr_dout_q;
  logic [LC3_WORD_W-1:0] data_dout_q;
  logic                  grant_write;

  lc3_mem_arbiter u_arbiter (
    .req_instr  (bus.instr_req),
    .req_data   (bus.data_req),
    .last_grant (last_grant),
    .grant_id   (grant_id)
  );

  assign grant_write = (grant_id == PORT_DATA) && bus.data_we;

  // Access sequencer: grant in IDLE, count wait states in ACCESS, strobe
  // or capture in the final ACCESS cycle, then pulse done for one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant   <= PORT_INSTR;
      grant_q      <= PORT_INSTR;
      we_pending   <= 1'b0;
      done_instr   <= 1'b0;
      done_data    <= 1'b0;
      busy_q       <= 1'b0;
      sram_addr_q  <= '0;
      sram_we_q    <= 1'b0;
      sram_wdata_q <= '0;
      instr_dout_q <= '0;
      data_dout_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          sram_we_q <= 1'b0;
          if (bus.instr_req || bus.data_req) begin
            grant_q    <= grant_id;
            last_grant <= grant_id;
            cnt        <= CNT_LOAD;
            we_pending <= grant_write;
            busy_q     <= 1'b1;
            state      <= ACCESS;
            // With no wait states the next cycle is already the final one.
            sram_we_q  <= grant_write && NO_WAIT;
            if (grant_id == PORT_DATA) begin
              sram_addr_q  <= bus.data_addr;
              sram_wdata_q <= bus.data_din;
            end else begin
              sram_addr_q  <= bus.instr_addr;
            end
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt       <= cnt - CNT_ONE;
            // Raise the strobe so it lines up with the cycle where cnt==0.
            sram_we_q <= we_pending && (cnt == CNT_ONE);
          end else begin
            sram_we_q <= 1'b0;
            if (!we_pending) begin
              if (grant_q == PORT_DATA) data_dout_q  <= bus.sram_rdata;
              else                      instr_dout_q <= bus.sram_rdata;
            end
            done_instr <= (grant_q == PORT_INSTR);
            done_data  <= (grant_q == PORT_DATA);
            state      <= DONE;
          end
        end
        DONE: begin
          done_instr <= 1'b0;
          done_data  <= 1'b0;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          sram_we_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.complete_instr = ~bus.instr_req | done_instr;
  assign bus.complete_data  = ~bus.data_req  | done_data;
  assign bus.instr_dout     = instr_dout_q;
  assign bus.data_dout      = data_dout_q;
  assign bus.sram_addr      = sram_addr_q;
  assign bus.sram_we        = sram_we_q;
  assign bus.sram_wdata     = sram_wdata_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: drivers push expected responses,
// independent monitors pop and compare when the DUT completes or writes.
module tb_lc3_mem_responder;

  typedef struct packed {
    logic        st;
    logic [15:0] v;
  } dexp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wexp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   expect_abort = 1'b0;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  logic [15:0] exp_i [$];
  dexp_t       exp_d [$];
  wexp_t       exp_w [$];
  bit          grant_log [$];

  lc3_mem_responder_if ifc ();
  lc3_mem_responder_if ifc0 ();

  lc3_mem_responder #(.WAIT_STATES(1), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  lc3_mem_responder #(.WAIT_STATES(0), .CNT_W(4)) dut_w0 (
    .clock (clock),
    .reset (reset),
    .bus   (ifc0)
  );

  always #5 clock = ~clock;

  // SRAM model: combinational read, synchronous write.
  assign ifc.sram_rdata  = mem[ifc.sram_addr];
  assign ifc0.sram_rdata = mem[ifc0.sram_addr];

  always @(posedge clock) begin
    if (ifc.sram_we)  mem[ifc.sram_addr]  = ifc.sram_wdata;
    if (ifc0.sram_we) mem[ifc0.sram_addr] = ifc0.sram_wdata;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endfunction

  // Completion and write monitor.
  always @(negedge clock) begin : monitor
    dexp_t de;
    wexp_t we;
    if (!reset) begin
      if (ifc.instr_req && ifc.complete_instr) begin
        grant_log.push_back(1'b0);
        if (exp_i.size() == 0) fail("instr_unexpected_complete");
        else check("instr_dout", 32'(ifc.instr_dout), 32'(exp_i.pop_front()));
      end
      if (ifc.data_req && ifc.complete_data) begin
        grant_log.push_back(1'b1);
        if (exp_d.size() == 0) fail("data_unexpected_complete");
        else begin
          de = exp_d.pop_front();
          check("data_kind", 32'(ifc.data_we), 32'(de.st));
          if (!de.st) check("data_dout", 32'(ifc.data_dout), 32'(de.v));
        end
      end
      if (ifc.sram_we) begin
        check("we_only_while_busy", 32'(ifc.busy), 32'd1);
        if (!expect_abort) begin
          if (exp_w.size() == 0) fail("unexpected_write");
          else begin
            we = exp_w.pop_front();
            check("write_addr", 32'(ifc.sram_addr), 32'(we.a));
            check("write_data", 32'(ifc.sram_wdata), 32'(we.d));
          end
        end
      end
    end
  end

  task automatic issue_instr(input logic [15:0] a);
    @(posedge clock);
    #1;
    ifc.instr_req  = 1'b1;
    ifc.instr_addr = a;
    exp_i.push_back(ref_mem[a]);
  endtask

  task automatic issue_data(input logic we, input logic [15:0] a, input logic [15:0] d);
    @(posedge clock);
    #1;
    ifc.data_req  = 1'b1;
    ifc.data_we   = we;
    ifc.data_addr = a;
    ifc.data_din  = d;
    if (we) begin
      ref_mem[a] = d;
      exp_w.push_back({a, d});
      exp_d.push_back({1'b1, 16'h0000});
    end else begin
      exp_d.push_back({1'b0, ref_mem[a]});
    end
  endtask

  task automatic wait_done(input bit is_data, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (is_data ? ifc.complete_data : ifc.complete_instr) begin
        ok  = 1'b1;
        cyc = c;
        break;
      end
    end
    if (!ok) fail(is_data ? "data_timeout" : "instr_timeout");
  endtask

  task automatic rand_instr(input int n);
    int cyc;
    bit ok;
    for (int i = 0; i < n; i++) begin
      issue_instr(16'h3000 | 16'($urandom_range(0, 255)));
      wait_done(1'b0, cyc, ok);
      if ($urandom_range(0, 3) != 0) begin
        @(posedge clock);
        #1 ifc.instr_req = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clock);
      end
    end
    @(posedge clock);
    #1 ifc.instr_req = 1'b0;
  endtask

  task automatic rand_data(input int n);
    int cyc;
    bit ok;
    for (int i = 0; i < n; i++) begin
      issue_data(1'($urandom_range(0, 1)), 16'h4000 | 16'($urandom_range(0, 255)),
                 16'($urandom));
      wait_done(1'b1, cyc, ok);
      if ($urandom_range(0, 3) != 0) begin
        @(posedge clock);
        #1 ifc.data_req = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clock);
      end
    end
    @(posedge clock);
    #1 ifc.data_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  c1, c2;
    bit  ok1, ok2;
    logic [15:0] v;

    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      mem[16'h3000 + 16'(i)] = v;
      ref_mem[16'h3000 + 16'(i)] = v;
      v = 16'($urandom);
      mem[16'h4000 + 16'(i)] = v;
      ref_mem[16'h4000 + 16'(i)] = v;
    end
    mem[16'h3000] = 16'h1220;
    ref_mem[16'h3000] = 16'h1220;

    ifc.instr_req = 1'b0;  ifc.instr_addr = '0;
    ifc.data_req  = 1'b0;  ifc.data_we = 1'b0;
    ifc.data_addr = '0;    ifc.data_din = '0;
    ifc0.instr_req = 1'b0; ifc0.instr_addr = '0;
    ifc0.data_req  = 1'b0; ifc0.data_we = 1'b0;
    ifc0.data_addr = '0;   ifc0.data_din = '0;

    // Reset state.
    #2;
    check("rst_sram_addr_wdata", {ifc.sram_addr, ifc.sram_wdata}, 32'h0);
    check("rst_douts", {ifc.instr_dout, ifc.data_dout}, 32'h0);
    check("rst_we_busy_ci_cd", 32'({ifc.sram_we, ifc.busy, ifc.complete_instr, ifc.complete_data}),
          32'b0011);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Zero wait states, idle for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("w0_idle_ci_cd_busy_we",
            32'({ifc0.complete_instr, ifc0.complete_data, ifc0.busy, ifc0.sram_we}), 32'b1100);
    end
    // Zero wait states, single fetch completes two cycles after sampling.
    @(posedge clock);
    #1;
    ifc0.instr_req  = 1'b1;
    ifc0.instr_addr = 16'h3000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("w0_complete_instr", 32'(ifc0.complete_instr), 32'(k == 2));
    end
    check("w0_instr_dout", 32'(ifc0.instr_dout), 32'h1220);
    @(posedge clock);
    #1 ifc0.instr_req = 1'b0;

    // Single fetch, one wait state.
    issue_instr(16'h3000);
    wait_done(1'b0, c1, ok1);
    check("t1_latency", 32'(c1), 32'd3);
    check("t1_instr_dout", 32'(ifc.instr_dout), 32'h1220);
    @(posedge clock);
    #1 ifc.instr_req = 1'b0;

    // Store with address/data scribbled after grant, then read back.
    issue_data(1'b1, 16'h4000, 16'hBEEF);
    @(posedge clock);
    #1;
    ifc.data_addr = 16'h5555;
    ifc.data_din  = 16'h0000;
    wait_done(1'b1, c1, ok1);
    @(posedge clock);
    #1 ifc.data_req = 1'b0;
    check("t2_mem_4000", 32'(mem[16'h4000]), 32'h0000BEEF);
    issue_data(1'b0, 16'h4000, 16'h0000);
    wait_done(1'b1, c1, ok1);
    check("t2_load_back", 32'(ifc.data_dout), 32'h0000BEEF);
    @(posedge clock);
    #1 ifc.data_req = 1'b0;

    // Store abandoned by the requester after grant still commits.
    @(posedge clock);
    #1;
    ifc.data_req  = 1'b1;
    ifc.data_we   = 1'b1;
    ifc.data_addr = 16'h4010;
    ifc.data_din  = 16'h1234;
    ref_mem[16'h4010] = 16'h1234;
    exp_w.push_back({16'h4010, 16'h1234});
    @(posedge clock);
    #1 ifc.data_req = 1'b0;
    repeat (4) @(posedge clock);
    issue_data(1'b0, 16'h4010, 16'h0000);
    wait_done(1'b1, c1, ok1);
    @(posedge clock);
    #1 ifc.data_req = 1'b0;

    // Tie straight after reset: data first, instr second.
    do_reset();
    grant_log.delete();
    @(posedge clock);
    #1;
    ifc.instr_req  = 1'b1;
    ifc.instr_addr = 16'h3001;
    exp_i.push_back(ref_mem[16'h3001]);
    ifc.data_req   = 1'b1;
    ifc.data_we    = 1'b0;
    ifc.data_addr  = 16'h4000;
    exp_d.push_back({1'b0, ref_mem[16'h4000]});
    fork
      begin
        wait_done(1'b1, c2, ok2);
        @(posedge clock);
        #1 ifc.data_req = 1'b0;
      end
      begin
        wait_done(1'b0, c1, ok1);
        @(posedge clock);
        #1 ifc.instr_req = 1'b0;
      end
    join
    check("t3_data_latency", 32'(c2), 32'd3);
    check("t3_instr_latency", 32'(c1), 32'd7);
    check("t3_grant_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      check("t3_first_grant_data", 32'(grant_log[0]), 32'd1);
      check("t3_second_grant_instr", 32'(grant_log[1]), 32'd0);
    end

    // Both held for four accesses: grants must alternate.
    grant_log.delete();
    @(posedge clock);
    #1;
    ifc.instr_req  = 1'b1;
    ifc.instr_addr = 16'h3002;
    ifc.data_req   = 1'b1;
    ifc.data_we    = 1'b0;
    ifc.data_addr  = 16'h4001;
    repeat (2) begin
      exp_i.push_back(ref_mem[16'h3002]);
      exp_d.push_back({1'b0, ref_mem[16'h4001]});
    end
    ok1 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      #1;
      if (grant_log.size() >= 4) begin
        ok1 = 1'b1;
        break;
      end
    end
    if (!ok1) fail("t4_four_grants_timeout");
    @(posedge clock);
    #1;
    ifc.instr_req = 1'b0;
    ifc.data_req  = 1'b0;
    if (grant_log.size() >= 4) begin
      check("t4_grant_order", 32'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}),
            32'b1010);
    end

    // Reset during the final cycle of a store aborts the write.
    expect_abort = 1'b1;
    @(posedge clock);
    #1;
    ifc.data_req  = 1'b1;
    ifc.data_we   = 1'b1;
    ifc.data_addr = 16'h4020;
    ifc.data_din  = 16'hDEAD;
    repeat (3) @(negedge clock);
    check("t5_we_in_final_cycle", 32'(ifc.sram_we), 32'd1);
    #1;
    reset        = 1'b1;
    ifc.data_req = 1'b0;
    #1;
    check("t5_we_busy_after_reset", 32'({ifc.sram_we, ifc.busy}), 32'd0);
    check("t5_sram_addr_after_reset", 32'(ifc.sram_addr), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    expect_abort = 1'b0;
    @(negedge clock);
    check("t5_mem_unchanged", 32'(mem[16'h4020]), 32'(ref_mem[16'h4020]));
    check("t5_complete_data", 32'(ifc.complete_data), 32'd1);
    check("t5_busy_idle", 32'(ifc.busy), 32'd0);

    // Randomised concurrent traffic on both ports.
    fork
      rand_instr(40);
      rand_data(40);
    join

    repeat (10) @(posedge clock);
    check("drain_instr_queue", 32'(exp_i.size()), 32'd0);
    check("drain_data_queue", 32'(exp_d.size()), 32'd0);
    check("drain_write_queue", 32'(exp_w.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
